// File: rtl/memory_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : memory_cycle
//  Description : Memory-access stage of the 18-bit pipeline. Issues loads and
//                stores to a variable-latency data memory (req/ready plus
//                rvalid), stalls upstream while a transfer is pending, aborts
//                on timeout or out-of-range address, and registers the
//                write-back bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_cycle #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [4:0]        RD_M,
    input  logic [17:0]       PCPlus4M,
    input  logic [17:0]       WriteDataM,
    input  logic [17:0]       ALU_ResultM,
    input  logic [1:0]        RGB_M,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [17:0]       mem_wdata,
    output logic [1:0]        mem_rgb,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [17:0]       mem_rdata,
    output logic              StallM,
    output logic              mem_err,
    output logic              ValidW,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [4:0]        RD_W,
    output logic [17:0]       PCPlus4W,
    output logic [17:0]       ALU_ResultW,
    output logic [17:0]       ReadDataW,
    output logic [1:0]        RGB_W,
    output logic [17:0]       ResultW
);

    // Last counter value that still belongs to the REQ+WAIT window.
    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_memop;
    logic                w_oor;
    logic                w_issue;
    logic                w_timeout;
    logic                w_capture;
    logic                w_oor_err;
    logic                w_stall;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [17:0]         r_wdata;
    logic [17:0]         r_rdata;
    logic [1:0]          r_rgb;
    logic [7:0]          r_cnt;
    logic                r_err;

    // A store wins over a load when both control bits are set.
    assign w_memop = ValidM & (MemWriteM | ResultSrcM);
    assign w_oor   = |ALU_ResultM[17:ADDR_W];

    // Next-state decode: issue, handshake progress and timeout abort.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_timeout   = 1'b0;
        w_capture   = 1'b0;
        w_oor_err   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_memop) begin
                    if (w_oor) begin
                        w_oor_err = 1'b1;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    w_state_nxt = r_we ? S_DONE : S_WAIT;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_WAIT: begin
                // rvalid is only looked at here, so data coincident with
                // acceptance is never taken.
                if (mem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stall starts combinationally in the issuing IDLE cycle and ends in DONE.
    assign w_stall = w_issue | (r_state == S_REQ) | (r_state == S_WAIT);

    // Gating with rst makes both drop the instant reset is asserted.
    assign mem_req   = rst & (r_state == S_REQ);
    assign StallM    = rst & w_stall;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_rgb   = r_rgb;
    assign mem_err   = r_err;
    assign ResultW   = ResultSrcW ? ReadDataW : ALU_ResultW;

    // Transfer control: state, latched request fields, cycle counter, error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rgb   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_we    <= MemWriteM;
                r_addr  <= ALU_ResultM[ADDR_W-1:0];
                r_wdata <= WriteDataM;
                r_rgb   <= RGB_M;
                r_cnt   <= '0;
                r_rdata <= '0;
            end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_capture) begin
                r_rdata <= mem_rdata;
            end
            if (w_oor_err || w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // W-stage register: bubble while stalled, otherwise take the M bundle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ValidW      <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= '0;
            PCPlus4W    <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            RGB_W       <= '0;
        end else if (w_stall) begin
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
        end else begin
            ValidW      <= ValidM;
            RegWriteW   <= RegWriteM;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            RGB_W       <= RGB_M;
            ReadDataW   <= (r_state == S_DONE) ? r_rdata : 18'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_cycle
//  Description : Self-checking bench for memory_cycle with a behavioural
//                memory responder and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_cycle;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [17:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic [1:0]  RGB_M;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [17:0] mem_wdata;
    logic [1:0]  mem_rgb;
    logic        mem_ready, mem_rvalid;
    logic [17:0] mem_rdata;
    logic        StallM, mem_err;
    logic        ValidW, RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [17:0] PCPlus4W, ALU_ResultW, ReadDataW, ResultW;
    logic [1:0]  RGB_W;

    int checks = 0;
    int errors = 0;

    logic [17:0] dev_mem [0:1023];
    logic [17:0] ref_mem [0:1023];
    logic        exp_err;

    always #5 clk = ~clk;

    memory_cycle #(.ADDR_W(10), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .RGB_M(RGB_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rgb(mem_rgb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .StallM(StallM), .mem_err(mem_err),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .RGB_W(RGB_W), .ResultW(ResultW)
    );

    // Reference model: stall cycles, request cycles and returned load data
    // derived from the access rules; updates the reference memory and error.
    task automatic model_op(input logic v, input logic mw, input logic rs,
                            input logic [17:0] wd, input logic [17:0] alu,
                            input int rdy, input int rv,
                            output int e_st, output int e_rq, output logic [17:0] e_rd);
        logic memop;
        logic oor;
        memop = v & (mw | rs);
        oor   = (alu >> 10) != 18'd0;
        e_st = 0; e_rq = 0; e_rd = 18'd0;
        if (memop && oor) begin
            exp_err = 1'b1;
        end else if (memop && mw) begin
            if (rdy + 1 <= TO) begin
                e_st = 2 + rdy; e_rq = rdy + 1; ref_mem[alu[9:0]] = wd;
            end else begin
                e_st = 1 + TO; e_rq = TO; exp_err = 1'b1;
            end
        end else if (memop) begin
            if (rdy + 1 > TO) begin
                e_st = 1 + TO; e_rq = TO; exp_err = 1'b1;
            end else if (rdy + 1 + rv > TO) begin
                e_st = 1 + TO; e_rq = rdy + 1; exp_err = 1'b1;
            end else begin
                e_st = 2 + rdy + rv; e_rq = rdy + 1; e_rd = ref_mem[alu[9:0]];
            end
        end
    endtask

    // Drives one M-stage instruction and plays the memory: ready on the
    // (rdy+1)-th request cycle, rvalid on the rv-th cycle after acceptance.
    // Entered and left at posedge+1.
    task automatic run_op(input logic v, input logic rw, input logic mw, input logic rs,
                          input logic [4:0] rd, input logic [17:0] pc, input logic [17:0] wd,
                          input logic [17:0] alu, input logic [1:0] rgb,
                          input int rdy, input int rv,
                          output int stalls, output int reqs,
                          output logic we_s, output logic [9:0] addr_s,
                          output logic [17:0] wdata_s, output logic [1:0] rgb_s,
                          output int bubble_bad, output int unstable, output bit hung);
        bit accepted;
        bit done;
        int wcnt;
        ValidM = v; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
        RD_M = rd; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu; RGB_M = rgb;
        stalls = 0; reqs = 0; bubble_bad = 0; unstable = 0; hung = 0;
        we_s = 1'b0; addr_s = '0; wdata_s = '0; rgb_s = '0;
        accepted = 0; done = 0; wcnt = 0;
        while (!done) begin
            @(negedge clk);
            if (StallM !== 1'b1) begin
                done = 1;
            end else begin
                stalls++;
                if (stalls > 1 && (ValidW !== 1'b0 || RegWriteW !== 1'b0)) bubble_bad++;
                if (mem_req === 1'b1) begin
                    reqs++;
                    if (reqs == 1) begin
                        we_s = mem_we; addr_s = mem_addr; wdata_s = mem_wdata; rgb_s = mem_rgb;
                    end else if ({mem_we, mem_addr, mem_wdata, mem_rgb} !== {we_s, addr_s, wdata_s, rgb_s}) begin
                        unstable++;
                    end
                    if (reqs == rdy + 1) begin
                        mem_ready = 1'b1;
                        accepted  = 1;
                        if (mem_we === 1'b1) dev_mem[mem_addr] = mem_wdata;
                    end
                end else if (accepted) begin
                    wcnt++;
                    if (wcnt == rv) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = dev_mem[addr_s];
                    end
                end
                @(posedge clk);
                #1;
                mem_ready = 1'b0; mem_rvalid = 1'b0;
                if (stalls > 300) begin
                    hung = 1; done = 1;
                end
            end
        end
        if (!hung) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ValidM = 1'b1; RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 1'b1;
        RD_M = 5'd3; PCPlus4M = 18'h00100; WriteDataM = 18'h00001; ALU_ResultM = 18'h00020; RGB_M = 2'd1;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_req, StallM, mem_err} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: req/stall/err=%b expected 000", {mem_req, StallM, mem_err});
        end
        checks++;
        if ({ValidW, RegWriteW, ResultSrcW, RD_W, RGB_W} !== 10'd0) begin
            errors++; $display("FAIL reset_wctrl: got %h expected 0", {ValidW, RegWriteW, ResultSrcW, RD_W, RGB_W});
        end
        checks++;
        if ({PCPlus4W, ALU_ResultW, ReadDataW, ResultW} !== 72'd0) begin
            errors++; $display("FAIL reset_wdata: got %h expected 0", {PCPlus4W, ALU_ResultW, ReadDataW, ResultW});
        end
        ValidM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 1'b0;
        rst = 1'b1;
        exp_err = 1'b0;
    endtask

    task automatic test_alu();
        int st, rq, bb, us; logic we; logic [9:0] ad; logic [17:0] wdt; logic [1:0] tg; bit hg;
        run_op(1, 1, 0, 0, 5'd5, 18'h00444, 18'h0, 18'h01234, 2'd2, 0, 1,
               st, rq, we, ad, wdt, tg, bb, us, hg);
        checks++;
        if (hg || st != 0 || rq != 0) begin
            errors++; $display("FAIL alu_stall: stalls=%0d reqs=%0d expected 0 0", st, rq);
        end
        checks++;
        if ({RegWriteW, RD_W, ResultW} !== {1'b1, 5'd5, 18'h01234}) begin
            errors++; $display("FAIL alu_w: got rw=%b rd=%0d res=%h expected 1 5 01234", RegWriteW, RD_W, ResultW);
        end
    endtask

    task automatic test_store();
        int st, rq, bb, us, est, erq; logic we; logic [9:0] ad; logic [17:0] wdt, erd; logic [1:0] tg; bit hg;
        model_op(1, 1, 0, 18'h2ABCD, 18'h00010, 0, 1, est, erq, erd);
        run_op(1, 0, 1, 0, 5'd0, 18'h00008, 18'h2ABCD, 18'h00010, 2'd3, 0, 1,
               st, rq, we, ad, wdt, tg, bb, us, hg);
        checks++;
        if (hg || st != 2 || rq != 1) begin
            errors++; $display("FAIL store_timing: stalls=%0d reqs=%0d expected 2 1", st, rq);
        end
        checks++;
        if ({we, ad, wdt, tg} !== {1'b1, 10'h010, 18'h2ABCD, 2'd3}) begin
            errors++; $display("FAIL store_fields: we=%b addr=%h data=%h tag=%0d expected 1 010 2abcd 3", we, ad, wdt, tg);
        end
        checks++;
        if (RegWriteW !== 1'b0 || ValidW !== 1'b1) begin
            errors++; $display("FAIL store_w: rw=%b valid=%b expected 0 1", RegWriteW, ValidW);
        end
    endtask

    task automatic test_load();
        int st, rq, bb, us, est, erq; logic we; logic [9:0] ad; logic [17:0] wdt, erd; logic [1:0] tg; bit hg;
        dev_mem[10'h3FF] = 18'h15555;
        ref_mem[10'h3FF] = 18'h15555;
        model_op(1, 0, 1, 18'h0, 18'h003FF, 3, 2, est, erq, erd);
        run_op(1, 1, 0, 1, 5'd9, 18'h00ABC, 18'h0, 18'h003FF, 2'd1, 3, 2,
               st, rq, we, ad, wdt, tg, bb, us, hg);
        checks++;
        if (hg || st != 7 || rq != 4) begin
            errors++; $display("FAIL load_timing: stalls=%0d reqs=%0d expected 7 4", st, rq);
        end
        checks++;
        if (bb != 0 || us != 0) begin
            errors++; $display("FAIL load_bubble: bad_bubbles=%0d unstable=%0d expected 0 0", bb, us);
        end
        checks++;
        if ({ResultSrcW, ResultW, ValidW, we, ad} !== {1'b1, 18'h15555, 1'b1, 1'b0, 10'h3FF}) begin
            errors++; $display("FAIL load_w: rs=%b res=%h valid=%b we=%b addr=%h expected 1 15555 1 0 3ff",
                               ResultSrcW, ResultW, ValidW, we, ad);
        end
    endtask

    task automatic test_back_to_back();
        int st, rq, bb, us, est, erq, rdy, rv; logic we; logic [9:0] ad; logic [17:0] wdt, erd; logic [1:0] tg; bit hg;
        logic v, rw, mw, rs; logic [4:0] rd; logic [17:0] pc, wd, alu; logic [1:0] rgb;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 3) != 0); rw = 1'($urandom); mw = 1'($urandom); rs = 1'($urandom);
            rd = 5'($urandom); pc = 18'($urandom); wd = 18'($urandom); rgb = 2'($urandom);
            alu = (mw | rs) ? 18'($urandom_range(0, 15)) : 18'($urandom_range(0, 1023));
            rdy = $urandom_range(0, 3); rv = $urandom_range(1, 3);
            model_op(v, mw, rs, wd, alu, rdy, rv, est, erq, erd);
            run_op(v, rw, mw, rs, rd, pc, wd, alu, rgb, rdy, rv, st, rq, we, ad, wdt, tg, bb, us, hg);
            checks++;
            if (hg || st != est || rq != erq) begin
                errors++; $display("FAIL b2b_timing[%0d]: stalls=%0d reqs=%0d expected %0d %0d", i, st, rq, est, erq);
            end
            checks++;
            if ({ValidW, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, RGB_W} !== {v, rw, rs, rd, pc, alu, rgb}) begin
                errors++; $display("FAIL b2b_wbundle[%0d]: got %h expected %h", i,
                                   {ValidW, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, RGB_W},
                                   {v, rw, rs, rd, pc, alu, rgb});
            end
            checks++;
            if (ReadDataW !== erd || ResultW !== (rs ? erd : alu)) begin
                errors++; $display("FAIL b2b_result[%0d]: rdata=%h res=%h expected %h %h", i, ReadDataW, ResultW,
                                   erd, rs ? erd : alu);
            end
            checks++;
            if (mem_err !== exp_err || bb != 0 || us != 0) begin
                errors++; $display("FAIL b2b_misc[%0d]: err=%b bubbles=%0d unstable=%0d expected %b 0 0", i, mem_err, bb, us, exp_err);
            end
            if (erq > 0) begin
                checks++;
                if ({we, ad, tg, (mw ? wdt : 18'd0)} !== {mw, alu[9:0], rgb, (mw ? wd : 18'd0)}) begin
                    errors++; $display("FAIL b2b_fields[%0d]: got %h expected %h", i,
                                       {we, ad, tg, (mw ? wdt : 18'd0)}, {mw, alu[9:0], rgb, (mw ? wd : 18'd0)});
                end
            end
        end
    endtask

    task automatic test_oor();
        int st, rq, bb, us, est, erq; logic we; logic [9:0] ad; logic [17:0] wdt, erd; logic [1:0] tg; bit hg;
        model_op(1, 0, 1, 18'h0, 18'h00400, 0, 1, est, erq, erd);
        run_op(1, 1, 0, 1, 5'd4, 18'h00010, 18'h0, 18'h00400, 2'd0, 0, 1,
               st, rq, we, ad, wdt, tg, bb, us, hg);
        checks++;
        if (hg || st != 0 || rq != 0) begin
            errors++; $display("FAIL oor_timing: stalls=%0d reqs=%0d expected 0 0", st, rq);
        end
        checks++;
        if ({mem_err, ReadDataW, ValidW} !== {1'b1, 18'd0, 1'b1}) begin
            errors++; $display("FAIL oor_w: err=%b rdata=%h valid=%b expected 1 0 1", mem_err, ReadDataW, ValidW);
        end
    endtask

    task automatic test_timeout();
        int st, rq, bb, us, est, erq; logic we; logic [9:0] ad; logic [17:0] wdt, erd; logic [1:0] tg; bit hg;
        // Store that is never accepted must not reach memory.
        model_op(1, 1, 0, 18'h3C3C3, 18'h00007, 100, 1, est, erq, erd);
        run_op(1, 0, 1, 0, 5'd0, 18'h0, 18'h3C3C3, 18'h00007, 2'd0, 100, 1,
               st, rq, we, ad, wdt, tg, bb, us, hg);
        checks++;
        if (hg || st != est || rq != TO || mem_err !== 1'b1) begin
            errors++; $display("FAIL to_store: stalls=%0d reqs=%0d err=%b expected %0d %0d 1", st, rq, mem_err, est, TO);
        end
        model_op(1, 0, 1, 18'h0, 18'h00007, 0, 1, est, erq, erd);
        run_op(1, 1, 0, 1, 5'd2, 18'h0, 18'h0, 18'h00007, 2'd0, 0, 1,
               st, rq, we, ad, wdt, tg, bb, us, hg);
        checks++;
        if (hg || ReadDataW !== erd) begin
            errors++; $display("FAIL to_dropped: rdata=%h expected %h", ReadDataW, erd);
        end
        // Load with ready held low.
        model_op(1, 0, 1, 18'h0, 18'h00003, 100, 1, est, erq, erd);
        run_op(1, 1, 0, 1, 5'd6, 18'h0, 18'h0, 18'h00003, 2'd0, 100, 1,
               st, rq, we, ad, wdt, tg, bb, us, hg);
        checks++;
        if (hg || st != 1 + TO || rq != TO || {ReadDataW, ResultW, ValidW} !== {36'd0, 1'b1}) begin
            errors++; $display("FAIL to_ready: stalls=%0d reqs=%0d rdata=%h valid=%b expected %0d %0d 0 1",
                               st, rq, ReadDataW, ValidW, 1 + TO, TO);
        end
        // Load accepted but rvalid never comes.
        model_op(1, 0, 1, 18'h0, 18'h00003, 2, 50, est, erq, erd);
        run_op(1, 1, 0, 1, 5'd6, 18'h0, 18'h0, 18'h00003, 2'd0, 2, 50,
               st, rq, we, ad, wdt, tg, bb, us, hg);
        checks++;
        if (hg || st != est || rq != erq || ReadDataW !== 18'd0) begin
            errors++; $display("FAIL to_rvalid: stalls=%0d reqs=%0d rdata=%h expected %0d %0d 0", st, rq, ReadDataW, est, erq);
        end
    endtask

    task automatic test_reset_wait();
        ValidM = 1'b1; RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 1'b1;
        RD_M = 5'd7; PCPlus4M = 18'h00004; WriteDataM = 18'h0; ALU_ResultM = 18'h00020; RGB_M = 2'd2;
        @(negedge clk);                      // IDLE, issuing
        @(posedge clk); #1;
        @(negedge clk);                      // REQ
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);                      // WAIT
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, StallM, mem_err, ValidW, ResultW} !== 22'd0) begin
            errors++; $display("FAIL rstwait_async: req=%b stall=%b err=%b valid=%b res=%h expected all 0",
                               mem_req, StallM, mem_err, ValidW, ResultW);
        end
        exp_err = 1'b0;
        ValidM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 1'b0; RD_M = '0; PCPlus4M = '0;
        ALU_ResultM = '0; RGB_M = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 18'h3FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ValidW, RegWriteW, ResultSrcW, ReadDataW, ResultW, mem_req, StallM, mem_err} !== 42'd0) begin
            errors++; $display("FAIL rstwait_stray: valid=%b rdata=%h res=%h req=%b stall=%b err=%b expected all 0",
                               ValidW, ReadDataW, ResultW, mem_req, StallM, mem_err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dev_mem[i] = 18'(i * 37 + 5);
            ref_mem[i] = 18'(i * 37 + 5);
        end
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_back_to_back();
        test_oor();
        test_timeout();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Memory-access (M) stage of the 18-bit pipeline; consumes the M-stage bundle produced by the execute stage (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM, RGB_M).
- Performs loads and stores to a variable-latency data memory over a req/ready + rvalid handshake, and stalls upstream while a transfer is pending.
- Registers the W-stage bundle and drives ResultW back to execute-stage forwarding.

Parameters:
ADDR_W, 10, data-memory word-address width; ALU_ResultM[17:ADDR_W] must be zero.
TIMEOUT, 64, max cycles spent in REQ+WAIT before abort (range 2..255).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
ValidM  in  1  M-stage holds a real instruction
RegWriteM, MemWriteM, ResultSrcM  in  1 each  control bits; ResultSrcM=1 means load
RD_M  in  5  destination register
PCPlus4M, WriteDataM, ALU_ResultM  in  18 each  return PC, store data, address/ALU result
RGB_M  in  2  channel tag
mem_req  out  1  request valid
mem_we  out  1  1=store, 0=load
mem_addr  out  ADDR_W  word address
mem_wdata  out  18  store data
mem_rgb  out  2  channel tag with request
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  load data valid
mem_rdata  in  18  load data
StallM  out  1  freeze F/D/E/M pipeline registers
mem_err  out  1  sticky: timeout or out-of-range access
ValidW, RegWriteW, ResultSrcW  out  1 each  W-stage controls
RD_W  out  5  W destination
PCPlus4W, ALU_ResultW, ReadDataW  out  18 each  W data
RGB_W  out  2  W channel tag
ResultW  out  18  ResultSrcW ? ReadDataW : ALU_ResultW (combinational from W registers)

Behaviour:
- Reset: state=IDLE; every output 0 (mem_req, StallM, mem_err, all W registers, ResultW). Asserting rst mid-transfer drops mem_req immediately and abandons the transfer; late mem_rvalid after release is ignored in IDLE.
- memop = ValidM & (MemWriteM | ResultSrcM). Store wins if both bits are set.
- oor = ALU_ResultM[17:ADDR_W] != 0.
- IDLE:
  - If !memop: StallM=0; W registers load M bundle at the edge; ReadDataW=0.
  - If memop & oor: no request; StallM=0; W loads M with ReadDataW=0; mem_err<=1.
  - If memop & !oor: StallM=1 combinationally; latch address, data, tag and we; cycle counter cleared; next state REQ.
- REQ: mem_req=1, fields stable, StallM=1. Transitions when mem_ready: store -> DONE, load -> WAIT.
- WAIT: StallM=1. When mem_rvalid: capture mem_rdata; go DONE. mem_rvalid in the same cycle as mem_ready is not accepted; data arrives at least 1 cycle after acceptance.
- DONE: StallM=0; W loads M bundle (held stable by the stall) plus captured read data; next IDLE.
- While StallM=1, W registers load a bubble each edge (ValidW=0, RegWriteW=0); data fields hold. The register file is write-through, so the bubble is safe for forwarding.
- Timeout: counter increments each cycle in REQ/WAIT. Reaching TIMEOUT: mem_req drops; mem_err<=1; go DONE with read data 0; a store is dropped.
- mem_err clears only on reset.
- Latency in stall cycles: store = 2 + ready wait; load = 2 + ready wait + rvalid wait. Non-memory instructions: 0.
- Back-to-back memory ops: DONE -> IDLE re-evaluates the new M contents; no op is issued twice.

Test Plan:
- ALU op (ValidM=1, RegWriteM=1, RD_M=5, ALU_ResultM=0x1234) -> next edge: RegWriteW=1, RD_W=5, ResultW=0x1234, StallM stays 0.
- Store addr 0x010, data 0x2ABCD, mem_ready high immediately -> mem_req 1 cycle with mem_we=1, mem_addr=0x010, mem_wdata=0x2ABCD; StallM high 2 cycles; RegWriteW=0.
- Load addr 0x3FF, mem_ready after 3 cycles, rvalid 2 cycles later with 0x15555 -> StallM high 7 cycles, then ResultSrcW=1, ResultW=0x15555, ValidW=0 during the stall.
- Load with ALU_ResultM=0x00400 (out of range) -> no mem_req, mem_err=1, ReadDataW=0, StallM=0.
- mem_ready held low with TIMEOUT=8 -> mem_req drops after 8 cycles, mem_err=1, pipeline resumes with ReadDataW=0.
- Reset pulsed during WAIT -> mem_req=0 and StallM=0 asynchronously; stray rvalid afterwards leaves W outputs at 0.
